muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands and a destination register index.
- Computes the M-extension result over multiple cycles.
- Presents the result, write index and a one-cycle write strobe toward the register-file write port. The core stalls on busy.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sign_fix.sv | 52 +++++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int MULDIV_STEPS = 32;
  localparam int CNT_W        = $clog2(MULDIV_STEPS);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand conditioning: unsigned magnitudes, result-sign flags and detection of
// the divide cases that bypass iteration (divide by zero, signed overflow).
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  muldiv_op_e      op,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_result,
  output logic            neg_rem,
  output logic            special,
  output logic [XLEN-1:0] special_result
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;
  logic is_div;
  logic is_rem;
  logic div_zero;
  logic overflow;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && operand_a[XLEN-1];
    b_neg    = b_signed && operand_b[XLEN-1];

    // -0x80000000 wraps to itself, which is the correct unsigned magnitude 2^31
    mag_a      = a_neg ? (~operand_a + 1'b1) : operand_a;
    mag_b      = b_neg ? (~operand_b + 1'b1) : operand_b;
    neg_result = a_neg ^ b_neg;
    neg_rem    = a_neg;

    is_div   = op[2];
    is_rem   = op[1];
    div_zero = is_div && (operand_b == '0);
    overflow = ((op == OP_DIV) || (op == OP_REM)) &&
               (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    special  = div_zero || overflow;

    special_result = '0;
    if (div_zero)
      special_result = is_rem ? operand_a : '1;
    else if (overflow)
      special_result = is_rem ? '0 : operand_a;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: 32-step shift-add multiply / restoring divide
// with a registered done strobe and register-file write enable.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [REG_ADDR_W-1:0] dest_register,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] result_register,
  output logic                  write_en_out
);

  function automatic logic [XLEN-1:0] neg_word(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dword(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  muldiv_state_e          state, next_state;
  muldiv_op_e             op_in, op_q;
  logic [XLEN-1:0]        operand_q;
  logic [2*XLEN-1:0]      acc_q;
  logic [CNT_W-1:0]       counter_q;
  logic                   neg_result_q, neg_rem_q, special_q;

  logic [XLEN-1:0]        mag_a, mag_b, special_result;
  logic                   neg_result, neg_rem, special;
  logic                   accept;

  logic [XLEN:0]          mul_sum;
  logic [XLEN:0]          rem_sh;
  logic                   div_ge;
  logic [XLEN-1:0]        div_diff;
  logic [2*XLEN-1:0]      acc_step;
  logic [2*XLEN-1:0]      product;
  logic [XLEN-1:0]        final_value;

  assign op_in = muldiv_op_e'(funct3);

  muldiv_sign_fix u_sign_fix (
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .op             (op_in),
    .mag_a          (mag_a),
    .mag_b          (mag_b),
    .neg_result     (neg_result),
    .neg_rem        (neg_rem),
    .special        (special),
    .special_result (special_result)
  );

  assign accept = (state == IDLE) && start && !busy;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = special ? FINISH : RUN;
      RUN:     if (counter_q == CNT_W'(MULDIV_STEPS - 1)) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, operand_q};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = rem_sh >= {1'b0, operand_q};
    div_diff = rem_sh[XLEN-1:0] - operand_q;
    if (op_q[2])
      acc_step = {(div_ge ? div_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    else
      acc_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                          : {1'b0, acc_q[2*XLEN-1:1]};
  end

  always_comb begin
    product = neg_dword(neg_result_q, acc_q);
    case (op_q)
      OP_MUL:             final_value = product[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:           final_value = product[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:    final_value = neg_word(neg_result_q, acc_q[XLEN-1:0]);
      default:            final_value = neg_word(neg_rem_q, acc_q[2*XLEN-1:XLEN]);
    endcase
    if (special_q)
      final_value = acc_q[XLEN-1:0];
  end

  // Accept / iterate / finish boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      counter_q       <= '0;
      op_q            <= OP_MUL;
      operand_q       <= '0;
      acc_q           <= '0;
      neg_result_q    <= 1'b0;
      neg_rem_q       <= 1'b0;
      special_q       <= 1'b0;
      result          <= '0;
      result_register <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE) || (state == FINISH);
      done  <= (state == FINISH);

      if (accept) begin
        op_q            <= op_in;
        operand_q       <= op_in[2] ? mag_b : mag_a;
        acc_q           <= special ? {{XLEN{1'b0}}, special_result}
                                   : {{XLEN{1'b0}}, (op_in[2] ? mag_a : mag_b)};
        neg_result_q    <= neg_result;
        neg_rem_q       <= neg_rem;
        special_q       <= special;
        counter_q       <= '0;
        result_register <= dest_register;
      end else if (state == RUN) begin
        acc_q     <= acc_step;
        counter_q <= counter_q + 1'b1;
      end

      if (state == FINISH)
        result <= final_value;
    end
  end

  assign write_en_out = done && (result_register != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_register;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_register;
  logic        write_en_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .funct3          (funct3),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .dest_register   (dest_register),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .result_register (result_register),
    .write_en_out    (write_en_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b};          return p[31:0];  end
      3'd1: begin p = sa * sb;                          return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b});        return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};          return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ia / ib; return q;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = ia % ib; return q;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(posedge clock); #1; w++;
    end
    check("idle_wait_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit spoil);
    logic [31:0] exp_res;
    bit          special;
    int          exp_lat;
    int          n;
    exp_res = model(f, a, b);
    special = f[2] && (b == 32'd0 ||
              ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = special ? 1 : 33;
    wait_idle();
    @(negedge clock);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; dest_register = rd;
    @(posedge clock); #1;
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    funct3 = 3'($urandom_range(0, 7)); dest_register = 5'($urandom_range(0, 31));
    check("busy_after_accept", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 60) begin
      start = (spoil && n == 5) ? 1'b1 : 1'b0;
      @(posedge clock); #1; n++;
    end
    start = 1'b0;
    check($sformatf("latency_f%0d", f), 64'(n), 64'(exp_lat));
    check($sformatf("result_f%0d_a%0h_b%0h", f, a, b), 64'(result), 64'(exp_res));
    check("result_register", 64'(result_register), 64'(rd));
    check("write_en_out", 64'(write_en_out), 64'(rd != 5'd0));
    check("busy_in_done", 64'(busy), 64'd1);
    @(posedge clock); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_falls", 64'(busy), 64'd0);
    check("result_held", 64'(result), 64'(exp_res));
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          sel;
    int          done_seen;

    reset = 1'b1; start = 1'b0; funct3 = 3'd0;
    operand_a = '0; operand_b = '0; dest_register = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_register", 64'(result_register), 64'd0);
    check("rst_write_en", 64'(write_en_out), 64'd0);
    @(negedge clock); reset = 1'b0;

    run_op(3'd0, 32'd7, 32'd6, 5'd5, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 5'd10, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    run_op(3'd4, 32'd13, 32'd0, 5'd13, 1'b0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1'b1);
    run_op(3'd0, 32'd7, 32'd6, 5'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 5) b = b >> $urandom_range(4, 30);
      run_op(f, a, b, 5'($urandom_range(0, 31)), bit'(i % 5 == 0));
    end

    wait_idle();
    @(negedge clock);
    start = 1'b1; funct3 = 3'd0; operand_a = 32'd11; operand_b = 32'd13; dest_register = 5'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_write_en", 64'(write_en_out), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("no_done_after_abort", 64'(done_seen), 64'd0);
    check("idle_after_abort", 64'(busy), 64'd0);
    run_op(3'd0, 32'd3, 32'd3, 5'd15, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
